// File: rtl/mem_align_unit_if.sv
// Request/response and memory-side bus of the load/store alignment unit.
// The slave modport is the unit itself. The master modport is its environment,
// which is the CPU on the request side and the data memory on the mem side.
interface mem_align_unit_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32
);
  logic              req_valid;
  logic              req_ready;
  logic              req_we;
  logic [1:0]        req_size;
  logic              req_signed;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_wdata;
  logic              resp_valid;
  logic [DATA_W-1:0] resp_rdata;
  logic              resp_err;
  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_ack;
  logic [DATA_W-1:0] mem_rdata;

  modport slave (
    input  req_valid, req_we, req_size, req_signed, req_addr, req_wdata,
    input  mem_ack, mem_rdata,
    output req_ready, resp_valid, resp_rdata, resp_err,
    output mem_req, mem_we, mem_addr, mem_wdata
  );

  modport master (
    output req_valid, req_we, req_size, req_signed, req_addr, req_wdata,
    output mem_ack, mem_rdata,
    input  req_ready, resp_valid, resp_rdata, resp_err,
    input  mem_req, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/mem_align_unit.sv
// Big-endian load/store alignment engine for a word-wide memory without byte
// enables. Loads extract and extend the addressed lanes. Partial stores are
// done as a read-modify-write. Misaligned or illegal accesses are answered with
// an error and never reach memory.
module mem_align_unit #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  mem_align_unit_if.slave  bus
);
  localparam int NB    = DATA_W / 8;
  localparam int OFS_W = $clog2(NB);

  typedef enum logic [1:0] {IDLE, RD, WR, RESP} state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [1:0]        size_q, size_d;
  logic              sgn_q, sgn_d;
  logic              we_q, we_d;
  logic              err_q, err_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;

  // This function returns ones in the low 8*2^sz bits. The shift saturates to
  // zero at full width, so a full-width access yields all ones.
  function automatic logic [DATA_W-1:0] lane_mask(input logic [1:0] sz);
    return ~({DATA_W{1'b1}} << (8 << sz));
  endfunction

  // This function returns the distance from the LSB of the word to the LSB of
  // the addressed field. Offset 0 is the most significant lane.
  function automatic int lane_sh(input logic [OFS_W-1:0] ofs, input logic [1:0] sz);
    return DATA_W - 8 * int'(ofs) - (8 << sz);
  endfunction

  function automatic logic [DATA_W-1:0] extract(input logic [DATA_W-1:0] word,
                                                input logic [OFS_W-1:0]  ofs,
                                                input logic [1:0]        sz,
                                                input logic              sgn);
    logic [DATA_W-1:0] m;
    logic [DATA_W-1:0] v;
    m = lane_mask(sz);
    v = (word >> lane_sh(ofs, sz)) & m;
    // The expression m ^ (m >> 1) isolates the MSB of the field.
    if (sgn && |(v & (m ^ (m >> 1)))) v = v | ~m;
    return v;
  endfunction

  function automatic logic [DATA_W-1:0] insert(input logic [DATA_W-1:0] old,
                                               input logic [DATA_W-1:0] wd,
                                               input logic [OFS_W-1:0]  ofs,
                                               input logic [1:0]        sz);
    logic [DATA_W-1:0] m;
    int                sh;
    m  = lane_mask(sz);
    sh = lane_sh(ofs, sz);
    return (old & ~(m << sh)) | ((wd & m) << sh);
  endfunction

  function automatic logic bad_access(input logic [2:0] a, input logic [1:0] sz);
    case (sz)
      2'd0:    return 1'b0;
      2'd1:    return a[0];
      2'd2:    return |a[1:0];
      default: return (DATA_W == 32) ? 1'b1 : |a[2:0];
    endcase
  endfunction

  // State and captured-request registers. Reset abandons any access in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      addr_q      <= '0;
      size_q      <= '0;
      sgn_q       <= 1'b0;
      we_q        <= 1'b0;
      err_q       <= 1'b0;
      wdata_q     <= '0;
      mem_wdata_q <= '0;
      rdata_q     <= '0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      size_q      <= size_d;
      sgn_q       <= sgn_d;
      we_q        <= we_d;
      err_q       <= err_d;
      wdata_q     <= wdata_d;
      mem_wdata_q <= mem_wdata_d;
      rdata_q     <= rdata_d;
    end
  end

  // Next state. The load result and the merged write word are computed here.
  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    size_d      = size_q;
    sgn_d       = sgn_q;
    we_d        = we_q;
    err_d       = err_q;
    wdata_d     = wdata_q;
    mem_wdata_d = mem_wdata_q;
    rdata_d     = rdata_q;
    case (state_q)
      IDLE: begin
        if (bus.req_valid) begin
          addr_d  = bus.req_addr;
          size_d  = bus.req_size;
          sgn_d   = bus.req_signed;
          we_d    = bus.req_we;
          wdata_d = bus.req_wdata;
          rdata_d = '0;
          err_d   = bad_access(bus.req_addr[2:0], bus.req_size);
          if (err_d) begin
            state_d = RESP;
          end else if (bus.req_we && ((8 << bus.req_size) == DATA_W)) begin
            // A full-width store needs no read, so the word goes straight out.
            mem_wdata_d = bus.req_wdata;
            state_d     = WR;
          end else begin
            state_d = RD;
          end
        end
      end
      RD: begin
        if (bus.mem_ack) begin
          if (we_q) begin
            mem_wdata_d = insert(bus.mem_rdata, wdata_q, addr_q[OFS_W-1:0], size_q);
            state_d     = WR;
          end else begin
            rdata_d = extract(bus.mem_rdata, addr_q[OFS_W-1:0], size_q, sgn_q);
            state_d = RESP;
          end
        end
      end
      WR: begin
        if (bus.mem_ack) state_d = RESP;
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.req_ready  = (state_q == IDLE);
  assign bus.mem_req    = (state_q == RD) || (state_q == WR);
  assign bus.mem_we     = (state_q == WR);
  assign bus.mem_addr   = {addr_q[ADDR_W-1:OFS_W], {OFS_W{1'b0}}};
  assign bus.mem_wdata  = mem_wdata_q;
  assign bus.resp_valid = (state_q == RESP);
  assign bus.resp_rdata = rdata_q;
  assign bus.resp_err   = err_q && (state_q == RESP);
endmodule

// File: tb/tb_mem_align_unit.sv
// Directed bench for mem_align_unit. It drives a 32-bit and a 64-bit instance
// against a memory responder that has a configurable acknowledge delay.
module tb_mem_align_unit;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  mem_align_unit_if #(.DATA_W(32), .ADDR_W(32)) b32 ();
  mem_align_unit_if #(.DATA_W(64), .ADDR_W(32)) b64 ();

  mem_align_unit #(.DATA_W(32), .ADDR_W(32)) dut32 (.clk(clk), .rst_n(rst_n), .bus(b32));
  mem_align_unit #(.DATA_W(64), .ADDR_W(32)) dut64 (.clk(clk), .rst_n(rst_n), .bus(b64));

  logic [31:0] mem32 = 32'h0;
  logic [63:0] mem64 = 64'h0;
  int          dly_rd = 0;
  int          dly_wr = 0;
  assign b32.mem_rdata = mem32;
  assign b64.mem_rdata = mem64;

  int          n_chk = 0;
  int          n_pass = 0;

  int          m32_cnt = 0, m32_req = 0, m32_nrd = 0, m32_nwr = 0, m32_wchg = 0;
  logic [31:0] m32_raddr = 0, m32_waddr = 0, m32_wdata = 0, m32_wfirst = 0;
  int          m64_cnt = 0, m64_req = 0, m64_nrd = 0, m64_nwr = 0, m64_wchg = 0;
  logic [31:0] m64_raddr = 0, m64_waddr = 0;
  logic [63:0] m64_wdata = 0, m64_wfirst = 0;

  // Memory responder for the 32-bit unit. It acknowledges after the configured number of stall cycles.
  always @(negedge clk) begin
    if (b32.mem_req === 1'b1) begin
      m32_req++;
      if (b32.mem_we && m32_cnt == 0) m32_wfirst = b32.mem_wdata;
      else if (b32.mem_we && b32.mem_wdata != m32_wfirst) m32_wchg++;
      if (m32_cnt >= (b32.mem_we ? dly_wr : dly_rd)) begin
        b32.mem_ack = 1'b1;
        m32_cnt = 0;
        if (b32.mem_we) begin m32_nwr++; m32_waddr = b32.mem_addr; m32_wdata = b32.mem_wdata; end
        else begin m32_nrd++; m32_raddr = b32.mem_addr; end
      end else begin
        b32.mem_ack = 1'b0;
        m32_cnt++;
      end
    end else begin
      b32.mem_ack = 1'b0;
      m32_cnt = 0;
    end
  end

  // Memory responder for the 64-bit unit.
  always @(negedge clk) begin
    if (b64.mem_req === 1'b1) begin
      m64_req++;
      if (b64.mem_we && m64_cnt == 0) m64_wfirst = b64.mem_wdata;
      else if (b64.mem_we && b64.mem_wdata != m64_wfirst) m64_wchg++;
      if (m64_cnt >= (b64.mem_we ? dly_wr : dly_rd)) begin
        b64.mem_ack = 1'b1;
        m64_cnt = 0;
        if (b64.mem_we) begin m64_nwr++; m64_waddr = b64.mem_addr; m64_wdata = b64.mem_wdata; end
        else begin m64_nrd++; m64_raddr = b64.mem_addr; end
      end else begin
        b64.mem_ack = 1'b0;
        m64_cnt++;
      end
    end else begin
      b64.mem_ack = 1'b0;
      m64_cnt = 0;
    end
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    else n_pass++;
  endtask

  // This task presents one request and returns one cycle after the accept edge, which is cycle 1.
  task automatic send(input bit w64, input bit we, input logic [1:0] sz, input bit sgn,
                      input logic [31:0] addr, input logic [63:0] wd);
    @(posedge clk); #1;
    if (w64) begin
      b64.req_we = we; b64.req_size = sz; b64.req_signed = sgn;
      b64.req_addr = addr; b64.req_wdata = wd; b64.req_valid = 1'b1;
    end else begin
      b32.req_we = we; b32.req_size = sz; b32.req_signed = sgn;
      b32.req_addr = addr; b32.req_wdata = wd[31:0]; b32.req_valid = 1'b1;
    end
    @(posedge clk); #1;
    b32.req_valid = 1'b0;
    b64.req_valid = 1'b0;
  endtask

  task automatic wait_resp(input bit w64, output int lat, output logic [63:0] rd, output logic er);
    bit got;
    got = 1'b0; lat = 1; rd = '0; er = 1'b0;
    for (int i = 0; i < 300 && !got; i++) begin
      if ((w64 ? b64.resp_valid : b32.resp_valid) === 1'b1) begin
        got = 1'b1;
        rd  = w64 ? b64.resp_rdata : {32'h0, b32.resp_rdata};
        er  = w64 ? b64.resp_err : b32.resp_err;
      end else begin
        @(posedge clk); #1;
        lat++;
      end
    end
    chk("resp_seen", {63'h0, got}, 64'h1);
    @(posedge clk); #1;
    chk("resp_one_pulse", {63'h0, (w64 ? b64.resp_valid : b32.resp_valid)}, 64'h0);
  endtask

  task automatic xact(input bit w64, input bit we, input logic [1:0] sz, input bit sgn,
                      input logic [31:0] addr, input logic [63:0] wd,
                      output int lat, output logic [63:0] rd, output logic er);
    send(w64, we, sz, sgn, addr, wd);
    wait_resp(w64, lat, rd, er);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int          lat;
    logic [63:0] rd;
    logic        er;
    int          s_rd, s_wr, s_req, s_chg;

    b32.req_valid = 0; b32.req_we = 0; b32.req_size = 0; b32.req_signed = 0;
    b32.req_addr = 0; b32.req_wdata = 0;
    b64.req_valid = 0; b64.req_we = 0; b64.req_size = 0; b64.req_signed = 0;
    b64.req_addr = 0; b64.req_wdata = 0;

    repeat (3) @(posedge clk);
    #1;
    chk("rst_req_ready", {63'h0, b32.req_ready}, 64'h1);
    chk("rst_mem_req", {63'h0, b32.mem_req}, 64'h0);
    chk("rst_mem_we", {63'h0, b32.mem_we}, 64'h0);
    chk("rst_resp_valid", {63'h0, b32.resp_valid}, 64'h0);
    chk("rst_resp_err", {63'h0, b32.resp_err}, 64'h0);
    chk("rst_mem_addr", {32'h0, b32.mem_addr}, 64'h0);
    chk("rst_mem_wdata", {32'h0, b32.mem_wdata}, 64'h0);
    chk("rst_resp_rdata64", b64.resp_rdata, 64'h0);
    rst_n = 1'b1;

    // Test 1: signed and unsigned byte load from offset 1.
    mem32 = 32'h12F45678;
    s_rd = m32_nrd; s_wr = m32_nwr;
    xact(0, 0, 2'd0, 1, 32'h1001, 0, lat, rd, er);
    chk("t1_lat", lat, 2);
    chk("t1_sbyte", rd, 64'hFFFFFFF4);
    chk("t1_err", {63'h0, er}, 0);
    chk("t1_reads", m32_nrd - s_rd, 1);
    chk("t1_writes", m32_nwr - s_wr, 0);
    chk("t1_raddr", {32'h0, m32_raddr}, 64'h1000);
    xact(0, 0, 2'd0, 0, 32'h1001, 0, lat, rd, er);
    chk("t1_ubyte", rd, 64'h000000F4);

    // Test 2: halfword load at offset 2.
    mem32 = 32'h1234ABCD;
    xact(0, 0, 2'd1, 0, 32'h1002, 0, lat, rd, er);
    chk("t2_uhalf", rd, 64'h0000ABCD);
    xact(0, 0, 2'd1, 1, 32'h1002, 0, lat, rd, er);
    chk("t2_shalf", rd, 64'hFFFFABCD);

    // Test 3: RMW byte store with three stall cycles on each access.
    dly_rd = 3; dly_wr = 3;
    mem32 = 32'h11223344;
    s_rd = m32_nrd; s_wr = m32_nwr; s_req = m32_req; s_chg = m32_wchg;
    xact(0, 1, 2'd0, 0, 32'h2003, 64'hFFFFFFAA, lat, rd, er);
    chk("t3_lat", lat, 9);
    chk("t3_err", {63'h0, er}, 0);
    chk("t3_rdata", rd, 0);
    chk("t3_reads", m32_nrd - s_rd, 1);
    chk("t3_writes", m32_nwr - s_wr, 1);
    chk("t3_raddr", {32'h0, m32_raddr}, 64'h2000);
    chk("t3_waddr", {32'h0, m32_waddr}, 64'h2000);
    chk("t3_wdata", {32'h0, m32_wdata}, 64'h112233AA);
    chk("t3_req_cycles", m32_req - s_req, 8);
    chk("t3_wdata_stable", m32_wchg - s_chg, 0);

    // Test 4: full-word store, a misaligned half load, and the illegal dword size.
    dly_rd = 0; dly_wr = 0;
    s_rd = m32_nrd; s_wr = m32_nwr;
    xact(0, 1, 2'd2, 0, 32'h3000, 64'hDEADBEEF, lat, rd, er);
    chk("t4_lat", lat, 2);
    chk("t4_reads", m32_nrd - s_rd, 0);
    chk("t4_writes", m32_nwr - s_wr, 1);
    chk("t4_wdata", {32'h0, m32_wdata}, 64'hDEADBEEF);
    chk("t4_waddr", {32'h0, m32_waddr}, 64'h3000);
    s_req = m32_req;
    xact(0, 0, 2'd1, 0, 32'h1001, 0, lat, rd, er);
    chk("t4_mis_lat", lat, 1);
    chk("t4_mis_err", {63'h0, er}, 1);
    chk("t4_mis_rdata", rd, 0);
    xact(0, 0, 2'd3, 0, 32'h1000, 0, lat, rd, er);
    chk("t4_size3_err", {63'h0, er}, 1);
    chk("t4_no_mem_req", m32_req - s_req, 0);

    // Test 5: 64-bit word width.
    mem64 = 64'h0123456789ABCDEF;
    xact(1, 0, 2'd3, 0, 32'h4008, 0, lat, rd, er);
    chk("t5_dword_lat", lat, 2);
    chk("t5_dword", rd, 64'h0123456789ABCDEF);
    chk("t5_raddr", {32'h0, m64_raddr}, 64'h4008);
    xact(1, 0, 2'd2, 1, 32'h4004, 0, lat, rd, er);
    chk("t5_sword_lo", rd, 64'hFFFFFFFF89ABCDEF);
    mem64 = 64'h0011223344556677;
    s_chg = m64_wchg;
    xact(1, 1, 2'd1, 0, 32'h400A, 64'hBEEF, lat, rd, er);
    chk("t5_rmw_lat", lat, 3);
    chk("t5_rmw_wdata", m64_wdata, 64'h0011BEEF44556677);
    chk("t5_rmw_waddr", {32'h0, m64_waddr}, 64'h4008);
    chk("t5_wdata_stable", m64_wchg - s_chg, 0);
    s_req = m64_req;
    xact(1, 0, 2'd3, 0, 32'h4004, 0, lat, rd, er);
    chk("t5_mis_err", {63'h0, er}, 1);
    chk("t5_mis_lat", lat, 1);
    chk("t5_no_mem_req", m64_req - s_req, 0);

    // Test 6: asynchronous reset while the write is stalled.
    dly_wr = 1000;
    mem32 = 32'h11223344;
    s_wr = m32_nwr;
    send(0, 1, 2'd0, 0, 32'h2001, 64'h55);
    for (int i = 0; i < 20 && b32.mem_we !== 1'b1; i++) begin
      @(posedge clk); #1;
    end
    chk("t6_in_wr", {63'h0, b32.mem_we}, 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("t6_mem_req_drop", {63'h0, b32.mem_req}, 0);
    chk("t6_mem_we_drop", {63'h0, b32.mem_we}, 0);
    chk("t6_ready_in_rst", {63'h0, b32.req_ready}, 1);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    dly_wr = 0;
    chk("t6_ready_after", {63'h0, b32.req_ready}, 1);
    chk("t6_no_write", m32_nwr - s_wr, 0);
    mem32 = 32'hCAFEF00D;
    xact(0, 0, 2'd2, 0, 32'h2000, 0, lat, rd, er);
    chk("t6_load_lat", lat, 2);
    chk("t6_load", rd, 64'hCAFEF00D);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
